// File: rtl/ex_mem_skid.sv
// EX->MEM pipeline boundary: 2-entry skid buffer with valid/ready handshake and EX->EX forwarding source.
// Optional EX_MEM_STALL_CNT_EN adds a saturating stall_cnt output counting out_valid & !out_ready cycles.
`ifndef WORD_WIDTH
`define WORD_WIDTH 32
`endif

module ex_mem_skid #(
    parameter int unsigned WORD_WIDTH = `WORD_WIDTH,
    parameter int unsigned REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [WORD_WIDTH-1:0] in_result,
    input  logic                  in_zero,
    input  logic [REG_ADDR_W-1:0] in_rd,
    input  logic                  in_wb_en,
    input  logic                  in_mem_rd,
    input  logic                  in_mem_wr,
    input  logic [WORD_WIDTH-1:0] in_store_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [WORD_WIDTH-1:0] out_result,
    output logic                  out_zero,
    output logic [REG_ADDR_W-1:0] out_rd,
    output logic                  out_wb_en,
    output logic                  out_mem_rd,
    output logic                  out_mem_wr,
    output logic [WORD_WIDTH-1:0] out_store_data,
    output logic                  fwd_valid,
    output logic [REG_ADDR_W-1:0] fwd_rd,
    output logic [WORD_WIDTH-1:0] fwd_result
`ifdef EX_MEM_STALL_CNT_EN
    ,
    output logic [31:0]           stall_cnt
`endif
);

    typedef struct packed {
        logic [WORD_WIDTH-1:0] result;
        logic                  zero;
        logic [REG_ADDR_W-1:0] rd;
        logic                  wb_en;
        logic                  mem_rd;
        logic                  mem_wr;
        logic [WORD_WIDTH-1:0] store_data;
    } entry_t;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    state_t state;
    entry_t main_q;
    entry_t skid_q;
    entry_t in_entry_c;
    logic   in_fire_c;
    logic   out_fire_c;

    assign in_fire_c  = in_valid & in_ready;
    assign out_fire_c = out_valid & out_ready;

    // Incoming entry; a write to register 0 never reaches write-back.
    always_comb begin
        in_entry_c            = '0;
        in_entry_c.result     = in_result;
        in_entry_c.zero       = in_zero;
        in_entry_c.rd         = in_rd;
        in_entry_c.wb_en      = in_wb_en & (in_rd != '0);
        in_entry_c.mem_rd     = in_mem_rd;
        in_entry_c.mem_wr     = in_mem_wr;
        in_entry_c.store_data = in_store_data;
    end

    // Control bits of the head are cleared whenever it goes empty, so enables never outlive out_valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= EMPTY;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            main_q    <= '0;
            skid_q    <= '0;
        end else if (flush) begin
            state         <= EMPTY;
            in_ready      <= 1'b1;
            out_valid     <= 1'b0;
            main_q.wb_en  <= 1'b0;
            main_q.mem_rd <= 1'b0;
            main_q.mem_wr <= 1'b0;
        end else begin
            case (state)
                EMPTY: begin
                    if (in_fire_c) begin
                        main_q    <= in_entry_c;
                        state     <= ONE;
                        out_valid <= 1'b1;
                    end
                end
                ONE: begin
                    if (in_fire_c && out_fire_c) begin
                        main_q <= in_entry_c;
                    end else if (in_fire_c) begin
                        skid_q   <= in_entry_c;
                        state    <= TWO;
                        in_ready <= 1'b0;
                    end else if (out_fire_c) begin
                        state         <= EMPTY;
                        out_valid     <= 1'b0;
                        main_q.wb_en  <= 1'b0;
                        main_q.mem_rd <= 1'b0;
                        main_q.mem_wr <= 1'b0;
                    end
                end
                TWO: begin
                    if (out_fire_c) begin
                        main_q   <= skid_q;
                        state    <= ONE;
                        in_ready <= 1'b1;
                    end
                end
                default: begin
                    state     <= EMPTY;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                    main_q    <= '0;
                end
            endcase
        end
    end

    assign out_result     = main_q.result;
    assign out_zero       = main_q.zero;
    assign out_rd         = main_q.rd;
    assign out_wb_en      = main_q.wb_en;
    assign out_mem_rd     = main_q.mem_rd;
    assign out_mem_wr     = main_q.mem_wr;
    assign out_store_data = main_q.store_data;

    // Forwarding comes straight from the head register; wb_en is already qualified by validity.
    assign fwd_valid  = main_q.wb_en;
    assign fwd_rd     = main_q.rd;
    assign fwd_result = main_q.result;

`ifdef EX_MEM_STALL_CNT_EN
    // Saturating back-pressure counter, cleared only by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= 32'd0;
        end else if (out_valid && !out_ready && (stall_cnt != 32'hFFFF_FFFF)) begin
            stall_cnt <= stall_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: doc/ex_mem_skid.md
Name: ex_mem_skid

Overview:
- Execute-to-memory stage boundary, directly downstream of the ALU.
- Captures the ALU result and zero flag with the instruction's control bits, and presents them to the memory stage over a valid/ready handshake.
- A 2-entry skid buffer lets a memory-stage stall back-pressure execute without a combinational ready path.
- Also provides the EX->EX forwarding source that feeds back to the ALU operand muxes.

Parameters:
- WORD_WIDTH, default `WORD_WIDTH (32): datapath width of result and store data.
- REG_ADDR_W, default 5: destination register index width.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- flush  input  1  synchronous pipeline flush (branch mispredict/exception)
- in_valid  input  1  ALU-stage entry valid
- in_ready  output  1  this block can accept an entry
- in_result  input  WORD_WIDTH  ALU out
- in_zero  input  1  ALU zero flag
- in_rd  input  REG_ADDR_W  destination register
- in_wb_en  input  1  register write-back enable
- in_mem_rd  input  1  load
- in_mem_wr  input  1  store
- in_store_data  input  WORD_WIDTH  rt value for stores
- out_valid  output  1  memory-stage entry valid
- out_ready  input  1  memory stage accepts
- out_result, out_zero, out_rd, out_wb_en, out_mem_rd, out_mem_wr, out_store_data  output  same widths as inputs  head entry fields
- fwd_valid  output  1  forwarding source valid
- fwd_rd  output  REG_ADDR_W  forwarding register index
- fwd_result  output  WORD_WIDTH  forwarding value

Behaviour:
- Storage: main (head) register driving out_*, plus one skid register. States: EMPTY, ONE, TWO.
- Handshakes: in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
- in_ready = (state != TWO), driven from a flop, never combinationally from out_ready.
- out_valid = (state != EMPTY).
- EMPTY: in_fire -> ONE, main <= in.
- ONE:
  - in_fire & out_fire -> ONE, main <= in.
  - in_fire & !out_fire -> TWO, skid <= in.
  - !in_fire & out_fire -> EMPTY.
  - otherwise hold.
- TWO: out_fire -> ONE, main <= skid. No input is accepted in this state.
- Latency: 1 cycle from in_fire to out_valid when the buffer is empty. Order is strictly FIFO. No entry is dropped or duplicated.
- out_* hold stable while out_valid & !out_ready.
- Write to $0: on capture, if in_rd == 0 then the stored wb_en is forced to 0.
- Forwarding, driven from the main register only:
  - fwd_valid = out_valid & out_wb_en.
  - fwd_rd = out_rd.
  - fwd_result = out_result.
- flush = 1 at a clock edge: next state EMPTY, in_ready = 1. Any in_fire in that cycle is discarded. Data registers may hold stale values, but all valid/enable outputs read 0.
- Reset (rst_n low, any time, including mid-transfer): state EMPTY, in_ready = 1, out_valid = 0, fwd_valid = 0, and all out_* data/control outputs 0. The first edge after release behaves as EMPTY.
- No arithmetic is performed; widths pass through unchanged.

Optional Feature:
- Macro: EX_MEM_STALL_CNT_EN.
- Defined: adds output stall_cnt [31:0].
  - Increments on every cycle with out_valid & !out_ready.
  - Saturates at 32'hFFFF_FFFF.
  - Cleared only by rst_n; flush does not affect it.
- Undefined: port and counter are absent; behaviour is otherwise identical.

Test Plan:
- Reset with in_valid = 1 pending -> out_valid = 0, in_ready = 1, out_result = 0. First entry in_result = 32'h0000_0005 appears on out_result one cycle after the edge.
- Streaming with out_ready held 1, entries 1, 2, 3 on consecutive cycles -> out_result 1, 2, 3 on consecutive cycles; in_ready stays 1.
- out_ready = 0 while sending A = 32'hA, B = 32'hB, C = 32'hC -> in_ready drops after B is taken and C is held upstream. Raising out_ready then yields A, B, C in order with no loss.
- flush asserted in state TWO while in_valid = 1 -> next cycle out_valid = 0, in_ready = 1; the flushed-cycle input is never output.
- in_rd = 0 with in_wb_en = 1 -> out_wb_en = 0, fwd_valid = 0. in_rd = 8, result 32'h1234 -> fwd_valid = 1, fwd_rd = 8, fwd_result = 32'h1234.
- With EX_MEM_STALL_CNT_EN: 4 cycles of out_valid & !out_ready -> stall_cnt = 4; a flush does not clear it; rst_n does.
